// File: rtl/infer_mac_requant_pkg.sv
// -----------------------------------------------------------------------------
// infer_mac_pkg
// Shared widths, types, FIFO sizing and saturation bounds for the
// infer_mac_requant block (MAC accumulate -> bias -> round -> saturate).
// No ports; imported by the interface, the FIFO and the top.
// -----------------------------------------------------------------------------
package infer_mac_pkg;

    localparam int PROD_W     = 36;  // signed product from the 21s x 15ns multiplier
    localparam int ACC_W      = 44;  // 256 full-scale products cannot overflow
    localparam int BIAS_W     = 32;
    localparam int OUT_W      = 8;
    localparam int FIFO_DEPTH = 2;

    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [BIAS_W-1:0] bias_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    // One guard bit so the rounding constant can never wrap the sum.
    typedef logic signed [ACC_W:0]    rnd_t;
    typedef logic signed [OUT_W-1:0]  out_t;
    typedef logic [FIFO_CNT_W-1:0]    cnt_t;

    localparam rnd_t SAT_MAX = rnd_t'((2 ** (OUT_W - 1)) - 1);
    localparam rnd_t SAT_MIN = rnd_t'(-(2 ** (OUT_W - 1)));

    function automatic acc_t sext_prod(input prod_t p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic acc_t sext_bias(input bias_t b);
        return {{(ACC_W - BIAS_W){b[BIAS_W-1]}}, b};
    endfunction

endpackage

// File: rtl/infer_mac_requant_if.sv
// -----------------------------------------------------------------------------
// infer_mac_requant_if
// Bundles the product input stream (valid/ready/data/last + per-vector bias)
// and the requantised result stream (valid/ready/data).
//   slave  : view of infer_mac_requant (consumes products, produces results)
//   master : view of the surrounding datapath / bench
// -----------------------------------------------------------------------------
interface infer_mac_requant_if;
    import infer_mac_pkg::*;

    logic  in_valid;
    logic  in_ready;
    prod_t in_data;
    logic  in_last;
    bias_t bias;
    logic  out_valid;
    logic  out_ready;
    out_t  out_data;

    modport slave (
        input  in_valid, in_data, in_last, bias, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_last, bias, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/infer_mac_requant_fifo2.sv
// -----------------------------------------------------------------------------
// infer_mac_requant_fifo2
// Two-entry synchronous FIFO holding finished activations.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   push, push_data   write request and value (ignored when full)
//   pop               read request (ignored when empty)
//   head              current head entry
//   count             number of valid entries (0..2)
// -----------------------------------------------------------------------------
module infer_mac_requant_fifo2
    import infer_mac_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  out_t push_data,
    input  logic pop,
    output out_t head,
    output cnt_t count
);

    out_t                  mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && (count != cnt_t'(FIFO_DEPTH));
    assign do_pop  = pop  && (count != '0);
    assign head    = mem[rd_ptr];

    // NOTE: the storage is cleared on reset on purpose -- the head is visible
    // on out_data, which must read 0 while reset is applied.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leave the count unchanged.
            count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
        end
    end

endmodule

// File: rtl/infer_mac_requant.sv
// -----------------------------------------------------------------------------
// infer_mac_requant
// Accumulates signed products into one dot product per vector (delimited by
// in_last), adds a per-vector bias, rounds with an arithmetic right shift of
// SHIFT (half toward +inf), saturates to OUT_W bits and queues the result in a
// 2-entry FIFO behind a valid/ready output.
// Pipeline: accept last beat -> S1 sum -> S2 round -> S3 saturate -> FIFO.
// Ports:
//   clk         clock
//   reset       synchronous active-low reset
//   bus         infer_mac_requant_if.slave: in_valid/in_ready/in_data/in_last/
//               bias and out_valid/out_ready/out_data
//   sat_sticky  set when any result was clamped; cleared only by reset
// Build option:
//   INFER_MAC_RELU_EN  negative results become 0 (not counted as saturation)
// -----------------------------------------------------------------------------
module infer_mac_requant
    import infer_mac_pkg::*;
#(
    parameter int SHIFT = 16  // 0..ACC_W-1
) (
    input  logic                 clk,
    input  logic                 reset,
    infer_mac_requant_if.slave   bus,
    output logic                 sat_sticky
);

    acc_t acc;
    acc_t beat_sum;
    logic accept;
    logic ready_en;

    logic s1_valid;
    acc_t s1_sum;
    rnd_t sum_ext;
    rnd_t rounded;

    logic s2_valid;
    rnd_t s2_r;
    out_t sat_data;
    logic sat_hit;

    logic s3_valid;
    out_t s3_data;

    cnt_t       fifo_count;
    logic [2:0] pending;

    assign accept   = bus.in_valid && bus.in_ready;
    assign beat_sum = acc + sext_prod(bus.in_data);

    // Every result already in flight owns a FIFO slot; S3 is counted as well
    // because it is a full register stage ahead of the FIFO write.
    assign pending      = 3'(fifo_count) + 3'(s1_valid) + 3'(s2_valid) + 3'(s3_valid);
    assign bus.in_ready = ready_en && (pending < 3'(FIFO_DEPTH));

    // Round half toward +inf: add half an LSB of the result, then shift.
    assign sum_ext = {s1_sum[ACC_W-1], s1_sum};
    if (SHIFT > 0) begin : g_round
        localparam rnd_t HALF = rnd_t'(1) << (SHIFT - 1);
        assign rounded = (sum_ext + HALF) >>> SHIFT;
    end else begin : g_no_round
        assign rounded = sum_ext;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        sat_data = s2_r[OUT_W-1:0];
        sat_hit  = 1'b0;
`ifdef INFER_MAC_RELU_EN
        if (s2_r[ACC_W]) begin
            sat_data = '0;
        end else if (s2_r > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_W-1:0];
            sat_hit  = 1'b1;
        end
`else
        if (s2_r > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_W-1:0];
            sat_hit  = 1'b1;
        end else if (s2_r < SAT_MIN) begin
            sat_data = SAT_MIN[OUT_W-1:0];
            sat_hit  = 1'b1;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments only, so every stage
    // samples the previous stage's value from before this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc        <= '0;
            ready_en   <= 1'b0;
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s2_valid   <= 1'b0;
            s2_r       <= '0;
            s3_valid   <= 1'b0;
            s3_data    <= '0;
            sat_sticky <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            // Accumulate; the last beat folds in the bias and restarts at 0.
            s1_valid <= accept && bus.in_last;
            if (accept) begin
                if (bus.in_last) begin
                    s1_sum <= beat_sum + sext_bias(bus.bias);
                    acc    <= '0;
                end else begin
                    acc <= beat_sum;
                end
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_r <= rounded;
            end

            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_data <= sat_data;
                if (sat_hit) begin
                    sat_sticky <= 1'b1;
                end
            end
        end
    end

    infer_mac_requant_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s3_valid),
        .push_data (s3_data),
        .pop       (bus.out_valid && bus.out_ready),
        .head      (bus.out_data),
        .count     (fifo_count)
    );

    assign bus.out_valid = (fifo_count != '0);

endmodule

// File: tb/tb_infer_mac_requant.sv
// -----------------------------------------------------------------------------
// tb_infer_mac_requant
// Self-checking bench for infer_mac_requant with SHIFT=4, OUT_W=8.
// Expected results come from a reference model using integer arithmetic
// (floor division) and from a table of hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_infer_mac_requant;

    localparam int SHIFT = 4;
    localparam longint OMAX = 127;
    localparam longint OMIN = -128;

    logic clk = 1'b0;
    logic reset;
    logic sat_sticky;
    logic ready_ctl = 1'b1;
    logic rnd_en = 1'b0;
    logic rnd_bit = 1'b1;

    int checks = 0;
    int failures = 0;
    int out_cnt = 0;
    int push_cnt = 0;
    longint exp_q[$];
    longint model_acc = 0;
    bit model_sticky = 1'b0;

    infer_mac_requant_if bus ();

    infer_mac_requant #(.SHIFT(SHIFT)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .sat_sticky (sat_sticky)
    );

    always #5 clk = ~clk;

    assign bus.out_ready = rnd_en ? rnd_bit : ready_ctl;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: round-half-up division by 2^SHIFT, then clamp.
    function automatic void model_result(input longint sum, output longint res, output bit sat);
        longint r;
        if (SHIFT > 0) r = floor_div(sum + (64'sd1 <<< (SHIFT - 1)), 64'sd1 <<< SHIFT);
        else           r = sum;
        sat = 1'b0;
`ifdef INFER_MAC_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > OMAX) begin res = OMAX; sat = 1'b1; end
        else if (r < OMIN) begin res = OMIN; sat = 1'b1; end
        else res = r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input longint d, input bit last, input longint b);
        int waited = 0;
        longint res;
        bit sat;
        bus.in_valid = 1'b1;
        bus.in_data  = d[35:0];
        bus.in_last  = last;
        bus.bias     = b[31:0];
        while (!bus.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_wait", bus.in_ready, 1);
        end else begin
            model_acc = model_acc + d;
            if (last) begin
                model_result(model_acc + b, res, sat);
                model_acc = 0;
                exp_q.push_back(res);
                push_cnt++;
                model_sticky = model_sticky | sat;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", bus.out_valid, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Output scoreboard: a transfer happens at the next posedge.
    always @(negedge clk) begin
        #1;
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", bus.out_valid, 0);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
            out_cnt++;
        end
    end

    function automatic longint rand_prod();
        longint v;
        case ($urandom_range(0, 3))
            0: v = longint'($urandom_range(0, 600)) - 300;
            1: v = longint'($urandom_range(0, 6000)) - 3000;
            2: begin
                v = longint'({$urandom(), $urandom()});
                v = (v <<< 28) >>> 28;
            end
            default: v = ($urandom_range(0, 1) != 0) ? -64'sd34359738368 : 64'sd34359738367;
        endcase
        return v;
    endfunction

    function automatic longint rand_bias();
        if ($urandom_range(0, 1) != 0) return longint'($urandom_range(0, 1000)) - 500;
        return longint'(int'($urandom()));
    endfunction

    typedef struct {
        int     n;
        longint beats[4];
        longint bias;
        longint exp;
        bit     exp_sat;
    } vec_t;

    function automatic vec_t mk(input int n, input longint b0, input longint b1,
                                input longint b2, input longint b3, input longint bias,
                                input longint exp, input bit sat);
        vec_t v;
        v.n = n;
        v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2; v.beats[3] = b3;
        v.bias = bias;
        v.exp = exp;
        v.exp_sat = sat;
        return v;
    endfunction

    initial begin
        vec_t   tbl[$];
        longint exp_eff;
        bit     sat_eff;
        bit     tbl_sticky = 1'b0;
        int     c0;
        longint big = -64'sd34359738368;

        tbl.push_back(mk(1, 24, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, -24, 0, 0, 0, 0, -1, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, -8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, -9, 0, 0, 0, 0, -1, 0));
        tbl.push_back(mk(2, 100, -50, 0, 0, -1000, -59, 0));
        tbl.push_back(mk(1, 2039, 0, 0, 0, 0, 127, 0));
        tbl.push_back(mk(1, 2040, 0, 0, 0, 0, 127, 1));
        tbl.push_back(mk(1, -2056, 0, 0, 0, 0, -128, 0));
        tbl.push_back(mk(1, -2057, 0, 0, 0, 0, -128, 1));
        tbl.push_back(mk(1, 4000, 0, 0, 0, 0, 127, 1));
        tbl.push_back(mk(1, -4000, 0, 0, 0, 0, -128, 1));
        tbl.push_back(mk(4, big, big, big, big, -64'sd2147483648, -128, 1));

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.bias     = '0;
        reset        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_sticky", sat_sticky, 0);
        check("rst_in_ready", bus.in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        // Multi-beat vector and latency
        send_beat(16, 0, 0);
        send_beat(32, 0, 0);
        send_beat(48, 0, 0);
        send_beat(-8, 1, 8);
        check("lat_edge0", bus.out_valid, 0);
        @(negedge clk);
        check("lat_edge1", bus.out_valid, 0);
        @(negedge clk);
        check("lat_edge2", bus.out_valid, 0);
        @(negedge clk);
        check("lat_edge3", bus.out_valid, 1);
        check("t1_data", bus.out_data, 6);
        check("t1_sticky", sat_sticky, 0);
        @(negedge clk);

        // Table of rounding / saturation boundaries
        foreach (tbl[k]) begin
            exp_eff = tbl[k].exp;
            sat_eff = tbl[k].exp_sat;
`ifdef INFER_MAC_RELU_EN
            if (exp_eff < 0) begin
                exp_eff = 0;
                sat_eff = 1'b0;
            end
`endif
            for (int i = 0; i < tbl[k].n; i++) begin
                send_beat(tbl[k].beats[i], i == tbl[k].n - 1, tbl[k].bias);
            end
            wait_out();
            check($sformatf("tbl%0d_data", k), bus.out_data, exp_eff);
            @(negedge clk);
            tbl_sticky = tbl_sticky | sat_eff;
            check($sformatf("tbl%0d_sticky", k), sat_sticky, tbl_sticky);
        end

        // Backpressure: two results fill the slots, the third waits
        ready_ctl = 1'b0;
        c0 = out_cnt;
        send_beat(24, 1, 0);
        send_beat(40, 1, 0);
        check("bp_in_ready_low", bus.in_ready, 0);
        repeat (6) @(negedge clk);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_head", bus.out_data, 2);
        check("bp_in_ready_hold", bus.in_ready, 0);
        @(negedge clk);
        check("bp_head_stable", bus.out_data, 2);
        fork
            send_beat(56, 1, 0);
            begin
                repeat (4) @(negedge clk);
                ready_ctl = 1'b1;
            end
        join
        wait_drain();
        check("bp_count", out_cnt - c0, 3);

        // Reset in the middle of a vector with a result still queued
        ready_ctl = 1'b0;
        send_beat(24, 1, 0);
        wait_out();
        send_beat(100, 0, 0);
        send_beat(200, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_sticky", sat_sticky, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        push_cnt = push_cnt - exp_q.size();
        exp_q.delete();
        model_acc = 0;
        model_sticky = 1'b0;
        reset = 1'b1;
        ready_ctl = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready_back", bus.in_ready, 1);
        send_beat(16, 1, 0);
        wait_out();
        check("after_rst_data", bus.out_data, 1);
        @(negedge clk);
        check("after_rst_sticky", sat_sticky, 0);

`ifdef INFER_MAC_RELU_EN
        send_beat(-64, 1, 0);
        wait_out();
        check("relu_data", bus.out_data, 0);
        @(negedge clk);
        check("relu_sticky", sat_sticky, 0);
`endif

        // Randomised vectors with random out_ready
        rnd_en = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                send_beat(rand_prod(), i == n - 1, rand_bias());
                if ($urandom_range(0, 7) == 0) @(negedge clk);
            end
        end
        rnd_en = 1'b0;
        ready_ctl = 1'b1;
        wait_drain();
        repeat (3) @(negedge clk);
        check("total_outputs", out_cnt, push_cnt);
        check("final_sticky", sat_sticky, model_sticky);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
